// File: rtl/bus_register_bank.sv
// bus_register_bank: ten 8-bit bus registers with 16-bit pair inc/dec; LOAD_ONEHOT_CHECK_EN enables multi-hot load checking
module bus_register_bank (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  data_in,
   input  logic        load_0,
   input  logic        load_1,
   input  logic        load_2,
   input  logic        load_3,
   input  logic        load_4,
   input  logic        load_5,
   input  logic        load_6,
   input  logic        load_7,
   input  logic        load_8,
   input  logic        load_9,
   input  logic        pair_inc,
   input  logic        pair_dec,
   input  logic [1:0]  pair_sel,
   input  logic        err_clr,
   output logic [7:0]  reg_0,
   output logic [7:0]  reg_1,
   output logic [7:0]  reg_2,
   output logic [7:0]  reg_3,
   output logic [7:0]  reg_4,
   output logic [7:0]  reg_5,
   output logic [7:0]  reg_6,
   output logic [7:0]  reg_7,
   output logic [7:0]  reg_8,
   output logic [7:0]  reg_9,
   output logic [15:0] pair_out,
   output logic        load_error
);
   logic [7:0]  r [10];
   logic [9:0]  ld, wr;
   logic        multi, pair_op;
   logic [15:0] pair_next;
   assign ld = {load_9, load_8, load_7, load_6, load_5, load_4, load_3, load_2, load_1, load_0};
   assign multi = (ld & (ld - 10'd1)) != 10'd0;
   assign pair_op = ~|ld & (pair_inc ^ pair_dec);
   assign pair_out = pair_sel == 2'd0 ? {r[0], r[1]} :
                     pair_sel == 2'd1 ? {r[2], r[3]} :
                     pair_sel == 2'd2 ? {r[4], r[5]} : {r[6], r[7]};
   assign pair_next = pair_out + (pair_inc ? 16'h0001 : 16'hFFFF);
`ifdef LOAD_ONEHOT_CHECK_EN
   assign wr = multi ? 10'd0 : ld;
   always_ff @(posedge clk) begin
      if (!rst_n) load_error <= 1'b0;
      else if (multi) load_error <= 1'b1;
      else if (err_clr) load_error <= 1'b0;
   end
`else
   logic unused_err_clr;
   assign wr = ld;
   assign load_error = 1'b0;
   assign unused_err_clr = err_clr ^ multi;
`endif
   genvar i;
   for (i = 0; i < 10; i++) begin : g_reg
      localparam bit IN_PAIR = i < 8;
      always_ff @(posedge clk) begin
         if (!rst_n) r[i] <= 8'h00;
         else if (wr[i]) r[i] <= data_in;
         else if (IN_PAIR && pair_op && pair_sel == 2'(i / 2))
            r[i] <= (i % 2 == 0) ? pair_next[15:8] : pair_next[7:0];
      end
   end
   assign reg_0 = r[0];
   assign reg_1 = r[1];
   assign reg_2 = r[2];
   assign reg_3 = r[3];
   assign reg_4 = r[4];
   assign reg_5 = r[5];
   assign reg_6 = r[6];
   assign reg_7 = r[7];
   assign reg_8 = r[8];
   assign reg_9 = r[9];
endmodule

// File: tb/tb_bus_register_bank.sv
// tb_bus_register_bank: directed self-checking bench for bus_register_bank (both LOAD_ONEHOT_CHECK_EN builds)
module tb_bus_register_bank;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  data_in = 8'h00;
   logic [9:0]  lds = 10'd0;
   logic        pair_inc = 1'b0, pair_dec = 1'b0, err_clr = 1'b0;
   logic [1:0]  pair_sel = 2'd0;
   logic [7:0]  q [10];
   logic [15:0] pair_out;
   logic        load_error;
   int          n_checks = 0, n_fail = 0;

   bus_register_bank dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in),
      .load_0(lds[0]), .load_1(lds[1]), .load_2(lds[2]), .load_3(lds[3]), .load_4(lds[4]),
      .load_5(lds[5]), .load_6(lds[6]), .load_7(lds[7]), .load_8(lds[8]), .load_9(lds[9]),
      .pair_inc(pair_inc), .pair_dec(pair_dec), .pair_sel(pair_sel), .err_clr(err_clr),
      .reg_0(q[0]), .reg_1(q[1]), .reg_2(q[2]), .reg_3(q[3]), .reg_4(q[4]),
      .reg_5(q[5]), .reg_6(q[6]), .reg_7(q[7]), .reg_8(q[8]), .reg_9(q[9]),
      .pair_out(pair_out), .load_error(load_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int k, input logic [7:0] d);
      lds = 10'(1) << k;
      data_in = d;
      step();
      lds = 10'd0;
   endtask

   initial begin
      step();
      step();
      for (int k = 0; k < 10; k++) check($sformatf("reset_reg%0d", k), 16'(q[k]), 16'h0000);
      check("reset_err", 16'(load_error), 16'h0000);
      rst_n = 1'b1;
      load(4, 8'hA5);
      check("load_reg4", 16'(q[4]), 16'h00A5);
      check("load_reg3", 16'(q[3]), 16'h0000);
      check("load_reg5", 16'(q[5]), 16'h0000);
      load(4, 8'hFF);
      load(5, 8'hFF);
      pair_sel = 2'd2;
      pair_inc = 1'b1;
      step();
      pair_inc = 1'b0;
      check("incwrap_reg4", 16'(q[4]), 16'h0000);
      check("incwrap_reg5", 16'(q[5]), 16'h0000);
      check("incwrap_pair", pair_out, 16'h0000);
      load(2, 8'h12);
      load(3, 8'h00);
      pair_sel = 2'd1;
      pair_dec = 1'b1;
      step();
      pair_dec = 1'b0;
      check("borrow_reg2", 16'(q[2]), 16'h0011);
      check("borrow_reg3", 16'(q[3]), 16'h00FF);
      load(0, 8'h00);
      load(1, 8'h10);
      pair_sel = 2'd0;
      pair_inc = 1'b1;
      lds = 10'(1) << 9;
      data_in = 8'h3C;
      step();
      lds = 10'd0;
      check("conflict_reg9", 16'(q[9]), 16'h003C);
      check("conflict_pair0", pair_out, 16'h0010);
      pair_dec = 1'b1;
      step();
      check("incdec_pair0", pair_out, 16'h0010);
      pair_dec = 1'b0;
      step();
      pair_inc = 1'b0;
      check("inc_pair0", pair_out, 16'h0011);
      pair_dec = 1'b1;
      step();
      check("b2b_dec1", pair_out, 16'h0010);
      step();
      pair_dec = 1'b0;
      check("b2b_dec2", pair_out, 16'h000F);
      pair_sel = 2'd1;
      #1;
      check("pairout_comb", pair_out, 16'h11FF);
      pair_sel = 2'd3;
      pair_dec = 1'b1;
      step();
      pair_dec = 1'b0;
      check("decwrap_pair3", pair_out, 16'hFFFF);
      check("decwrap_reg8", 16'(q[8]), 16'h0000);
      load(8, 8'h55);
      lds = 10'b01_0000_0010;
      data_in = 8'h77;
      pair_inc = 1'b1;
      step();
      lds = 10'd0;
      pair_inc = 1'b0;
      check("multi_pair3", pair_out, 16'hFFFF);
`ifdef LOAD_ONEHOT_CHECK_EN
      check("multi_reg1", 16'(q[1]), 16'h000F);
      check("multi_reg8", 16'(q[8]), 16'h0055);
      check("multi_err", 16'(load_error), 16'h0001);
      step();
      check("err_sticky", 16'(load_error), 16'h0001);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("err_clr", 16'(load_error), 16'h0000);
      lds = 10'b01_0000_0010;
      err_clr = 1'b1;
      step();
      lds = 10'd0;
      err_clr = 1'b0;
      check("err_set_wins", 16'(load_error), 16'h0001);
`else
      check("multi_reg1", 16'(q[1]), 16'h0077);
      check("multi_reg8", 16'(q[8]), 16'h0077);
      check("multi_err", 16'(load_error), 16'h0000);
      err_clr = 1'b1;
      lds = 10'b01_0000_0010;
      step();
      lds = 10'd0;
      err_clr = 1'b0;
      check("multi_err2", 16'(load_error), 16'h0000);
`endif
      rst_n = 1'b0;
      lds = 10'd1;
      data_in = 8'h99;
      step();
      lds = 10'd0;
      rst_n = 1'b1;
      check("rst_mid_reg0", 16'(q[0]), 16'h0000);
      check("rst_mid_reg8", 16'(q[8]), 16'h0000);
      check("rst_mid_err", 16'(load_error), 16'h0000);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/bus_register_bank.md
# bus_register_bank

Destination end of the CPU's internal 8-bit data bus: ten 8-bit registers, each loaded from the bus by its own one-hot load strobe. Register pairs 0/1, 2/3, 4/5 and 6/7 also support in-place 16-bit increment and decrement for the B-C, D-E, H-L and W-Z pairs. Every register value is driven continuously back to the bus-source selection logic and the ALU. An optional checker flags and suppresses illegal multi-hot load strobes.

## Interface
- No parameters; width 8 and count 10 are fixed.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- data_in  in  8  internal bus value
- load_0 … load_9  in  1 each  one-hot load strobes; load_k writes data_in into reg_k
- pair_inc  in  1  increment the selected pair
- pair_dec  in  1  decrement the selected pair
- pair_sel  in  2  pair select: 0 = (reg_0 hi, reg_1 lo), 1 = (reg_2, reg_3), 2 = (reg_4, reg_5), 3 = (reg_6, reg_7)
- err_clr  in  1  clears load_error
- reg_0 … reg_9  out  8 each  current register contents
- pair_out  out  16  {hi, lo} of the selected pair, combinational from the registers and pair_sel
- load_error  out  1  sticky multi-hot load flag

## Operation
- Reset (rst_n low at a rising edge): all reg_k = 8'h00 and load_error = 0. Reset overrides every other input.
- Load: exactly one load_k high at an edge sets reg_k = data_in. All other registers hold.
- No load high: all registers hold unless a pair operation applies.
- Pair operation: applies only when no load_k is high in that cycle and exactly one of pair_inc / pair_dec is high.
  - The selected 16-bit pair gets {hi,lo} ± 1, modulo 2^16.
  - Increment wraps 16'hFFFF → 16'h0000. Decrement wraps 16'h0000 → 16'hFFFF.
  - Carry and borrow propagate from lo into hi.
- Priority:
  - Any load in a cycle drops the pair operation entirely, even when the load targets another register.
  - pair_inc and pair_dec both high is a no-op.
- reg_8 and reg_9 (accumulator and temp) are byte-only and are never touched by pair operations.
- Multi-hot load (two or more load_k high):
  - Behaviour depends on the macro; see Configuration.
  - The pair operation is dropped in either case.
- load_error:
  - Set on the edge after a detected multi-hot load.
  - Cleared by err_clr.
  - If a set condition and err_clr occur in the same cycle, set wins.

## Timing
- Load latency: one cycle. reg_k shows data_in immediately after the edge on which load_k is sampled.
- Increment/decrement latency: one cycle. Back-to-back pair operations on consecutive cycles each take effect.
- pair_out has zero latency from pair_sel. Its value changes only combinationally, and after edges that update the selected pair.
- Read-after-write: a register that is loaded and read by the source mux in the same cycle supplies its old value. The new value is visible in the next cycle.
- Reset mid-operation: a load or pair operation sampled on the same edge as rst_n low is discarded.

## Configuration
- LOAD_ONEHOT_CHECK_EN defined:
  - A multi-hot load writes no register.
  - load_error is set on the next edge.
- LOAD_ONEHOT_CHECK_EN undefined:
  - A multi-hot load writes data_in into every register whose strobe is high.
  - load_error is tied to 0 and err_clr is ignored.
- The port list is identical in both builds.

## Test plan
- Reset then load: rst_n low for 2 cycles, then load_4 = 1 with data_in = 8'hA5 for one cycle → all regs 8'h00 after reset; reg_4 = 8'hA5 on the next cycle; all other regs 8'h00.
- Increment wrap: load reg_4 = 8'hFF and reg_5 = 8'hFF, then pair_sel = 2 with pair_inc for one cycle → reg_4 = 8'h00, reg_5 = 8'h00, pair_out = 16'h0000.
- Decrement borrow: reg_2 = 8'h12, reg_3 = 8'h00, pair_sel = 1, pair_dec → reg_2 = 8'h11, reg_3 = 8'hFF.
- Conflicts:
  - load_9 = 1 (data_in = 8'h3C) in the same cycle as pair_inc on pair 0 holding 16'h0010 → reg_9 = 8'h3C and pair 0 stays 16'h0010.
  - pair_inc and pair_dec both high → no change.
- Multi-hot, checker built in: load_1 and load_8 high with data_in = 8'h77 → reg_1 and reg_8 unchanged; load_error = 1 next cycle and stays 1 until err_clr.
  - Repeat with err_clr high in the same cycle as a multi-hot load → load_error stays 1.
- Multi-hot, checker built out: same stimulus as above → reg_1 = reg_8 = 8'h77 and load_error = 0.
